fma16_arb: RTL and testbench
============================

# fma16_arb

Two-requester arbiter and sequencer for the shared combinational `fma16` half-precision fused multiply-add unit. It accepts operations from two clients over valid/ready handshakes and grants them round-robin. It registers the operands into `fma16`, captures the result one cycle later, and returns result and flags to the issuing client. Per-client sticky exception flags and completed-operation counters are also kept for software/status readout.

## Interface
- No parameters; all widths fixed (fp16 operands, 4-bit flags {invalid, overflow, underflow, inexact}, 6-bit ctrl {roundmode[1:0], mul, add, negp, negz}).
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid[1:0]  in  2  per-client request valid.
- req_ready[1:0]  out  2  per-client request accept.
- req_x0, req_y0, req_z0 / req_x1, req_y1, req_z1  in  16 each  operands per client.
- req_ctrl0 / req_ctrl1  in  6 each  ctrl per client: [5:4] roundmode, [3] mul, [2] add, [1] negp, [0] negz.
- rsp_valid[1:0]  out  2  per-client response valid.
- rsp_ready[1:0]  in  2  per-client response accept.
- rsp_result  out  16  result (shared bus, meaningful for the client whose rsp_valid is set).
- rsp_flags  out  4  flags for that result.
- fma_x, fma_y, fma_z  out  16 each  registered operands to `fma16`.
- fma_roundmode  out  2, fma_mul / fma_add / fma_negp / fma_negz  out  1 each  registered controls to `fma16`.
- fma_result  in  16, fma_flags  in  4  combinational outputs of `fma16`.
- flag_clr[1:0]  in  2  per-client sticky-flag clear.
- sticky_flags0 / sticky_flags1  out  4 each  OR-accumulated flags per client.
- op_count0 / op_count1  out  16 each  completed operations per client, wraps at 16'hFFFF→0.

## Operation
- FSM states: IDLE, ISSUE, RESP. Only one operation is in flight.
- IDLE: grant = highest-priority client with req_valid set. req_ready[g] = 1 only for the granted client; the other is 0. req_ready is 0 in ISSUE and RESP.
- Accept (req_valid[g] & req_ready[g] at the edge): latch the operands and ctrl of client g into fma_* registers, set owner = g, go to ISSUE. Priority flips to the other client (round-robin). With no request, priority is unchanged.
- ISSUE (one cycle): `fma16` evaluates. At the edge, capture fma_result and fma_flags into response registers and go to RESP.
- RESP: rsp_valid[owner] = 1, the other rsp_valid = 0. Hold rsp_result and rsp_flags stable until rsp_ready[owner] = 1.
- On response handshake:
  - sticky_flags[owner] |= rsp_flags.
  - op_count[owner] += 1.
  - Return to IDLE.
- flag_clr[i]: sticky_flags[i] <= 0. If it coincides with a handshake for the same client, the result is sticky_flags[i] <= rsp_flags (clear first, then accumulate).
- fma_* registers hold their last value outside ISSUE. They change only on accept.
- rsp_ready from the non-owner is ignored. rsp_ready in IDLE/ISSUE is ignored.

## Timing
- Reset values:
  - state IDLE, priority = client 0, owner 0.
  - req_ready = 2'b00 during reset, rsp_valid = 2'b00.
  - fma_* = 0, rsp_result = 16'h0000, rsp_flags = 4'h0.
  - sticky_flags* = 0, op_count* = 0.
- Reset mid-operation (ISSUE or RESP) abandons the op without a response, leaves counters and flags at 0, and returns to IDLE.
- Latency: accept edge at cycle N; ISSUE during N+1; rsp_valid high from N+2. Minimum issue interval is 3 cycles (the next accept is possible in the cycle after the response handshake).
- Simultaneous requests in IDLE: the priority client wins; the loser's req_ready stays 0 and it must hold req_valid.
- req_ready is combinational from req_valid and state/priority. rsp_* are registered outputs.

## Test plan
- Single op, client 0, real `fma16`: x=3C00, y=4000, z=3C00, ctrl=6'b001100 (mul, add) → req_ready0=1 at accept; rsp_valid0=1 exactly 2 cycles later; rsp_result=4200, rsp_flags=0; op_count0=1.
- Contention: both clients valid from the cycle after reset → client 0 granted first, client 1 granted next (after client 0's response handshake), then client 0 again. Responses are each routed only to the issuer (rsp_valid1 stays 0 during client 0's response).
- Response backpressure: hold rsp_ready0=0 for 5 cycles with the bench stub driving fma_result=ABCD, fma_flags=4'b0001, then changing the stub to 0000/0 → rsp_result stays ABCD and rsp_valid0 stays 1 until ready; req_ready[1:0]=0 throughout.
- Sticky flags: client 1 completes two ops with the stub flags 4'b0100 then 4'b0001 → sticky_flags1=4'b0101; assert flag_clr[1] in the same cycle as a third handshake with flags 4'b1000 → sticky_flags1=4'b1000.
- Reset during RESP: reset for 1 cycle while rsp_valid0=1 → next cycle rsp_valid=0, state IDLE, op_count0=0, sticky_flags0=0, priority client 0.
- Counter wrap: force 65536 client-0 completions (or preload via a bench-driven loop) → op_count0 wraps from FFFF to 0000.

Source files
------------

// File: rtl/fma16_arb.sv
// Round-robin arbiter/sequencer sharing one combinational fma16 between two clients.
// Only one operation is in flight: accept -> ISSUE (fma16 evaluates) -> RESP (held until accepted).
module fma16_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_x0,
    input  logic [15:0] req_y0,
    input  logic [15:0] req_z0,
    input  logic [5:0]  req_ctrl0,
    input  logic [15:0] req_x1,
    input  logic [15:0] req_y1,
    input  logic [15:0] req_z1,
    input  logic [5:0]  req_ctrl1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic [15:0] fma_x,
    output logic [15:0] fma_y,
    output logic [15:0] fma_z,
    output logic [1:0]  fma_roundmode,
    output logic        fma_mul,
    output logic        fma_add,
    output logic        fma_negp,
    output logic        fma_negz,
    input  logic [15:0] fma_result,
    input  logic [3:0]  fma_flags,
    input  logic [1:0]  flag_clr,
    output logic [3:0]  sticky_flags0,
    output logic [3:0]  sticky_flags1,
    output logic [15:0] op_count0,
    output logic [15:0] op_count1
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_prio;
    logic        r_owner;
    logic [15:0] r_fma_x, r_fma_y, r_fma_z;
    logic [5:0]  r_fma_ctrl;
    logic [15:0] r_rsp_result;
    logic [3:0]  r_rsp_flags;
    logic [3:0]  r_sticky0, r_sticky1;
    logic [15:0] r_op_count0, r_op_count1;

    logic        w_grant;
    logic        w_grant_valid;
    logic        w_accept;
    logic        w_rsp_hs;
    logic [15:0] w_sel_x, w_sel_y, w_sel_z;
    logic [5:0]  w_sel_ctrl;
    logic [1:0]  w_own_hs;
    logic [3:0]  w_sticky_cur  [2];
    logic [3:0]  w_sticky_next [2];
    logic [15:0] w_count_cur   [2];
    logic [15:0] w_count_next  [2];

    // Priority client wins if it is requesting, otherwise the other client may take the slot.
    always_comb begin
        w_grant       = r_prio;
        w_grant_valid = req_valid[r_prio];
        if (!req_valid[r_prio]) begin
            w_grant       = ~r_prio;
            w_grant_valid = req_valid[~r_prio];
        end
    end

    assign w_accept   = |(req_valid & req_ready);
    assign w_rsp_hs   = (r_state == S_RESP) && rsp_ready[r_owner];

    assign w_sel_x    = w_grant ? req_x1    : req_x0;
    assign w_sel_y    = w_grant ? req_y1    : req_y0;
    assign w_sel_z    = w_grant ? req_z1    : req_z0;
    assign w_sel_ctrl = w_grant ? req_ctrl1 : req_ctrl0;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_RESP;
            S_RESP:  if (w_rsp_hs) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs; req_ready is forced low while reset is asserted
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (r_state == S_IDLE && !reset && w_grant_valid) begin
            req_ready[w_grant] = 1'b1;
        end
        if (r_state == S_RESP) begin
            rsp_valid[r_owner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio       <= 1'b0;
            r_owner      <= 1'b0;
            r_fma_x      <= 16'h0000;
            r_fma_y      <= 16'h0000;
            r_fma_z      <= 16'h0000;
            r_fma_ctrl   <= 6'h00;
            r_rsp_result <= 16'h0000;
            r_rsp_flags  <= 4'h0;
        end else begin
            if (w_accept) begin
                r_owner    <= w_grant;
                r_prio     <= ~w_grant;
                r_fma_x    <= w_sel_x;
                r_fma_y    <= w_sel_y;
                r_fma_z    <= w_sel_z;
                r_fma_ctrl <= w_sel_ctrl;
            end
            if (r_state == S_ISSUE) begin
                r_rsp_result <= fma_result;
                r_rsp_flags  <= fma_flags;
            end
        end
    end

    assign w_sticky_cur[0] = r_sticky0;
    assign w_sticky_cur[1] = r_sticky1;
    assign w_count_cur[0]  = r_op_count0;
    assign w_count_cur[1]  = r_op_count1;

    // Clear takes effect before the completing op's flags are accumulated.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_client
            assign w_own_hs[gi]      = w_rsp_hs && (r_owner == 1'(gi));
            assign w_sticky_next[gi] = (flag_clr[gi] ? 4'h0 : w_sticky_cur[gi])
                                     | (w_own_hs[gi] ? r_rsp_flags : 4'h0);
            assign w_count_next[gi]  = w_count_cur[gi] + {15'h0000, w_own_hs[gi]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky0   <= 4'h0;
            r_sticky1   <= 4'h0;
            r_op_count0 <= 16'h0000;
            r_op_count1 <= 16'h0000;
        end else begin
            r_sticky0   <= w_sticky_next[0];
            r_sticky1   <= w_sticky_next[1];
            r_op_count0 <= w_count_next[0];
            r_op_count1 <= w_count_next[1];
        end
    end

    assign fma_x         = r_fma_x;
    assign fma_y         = r_fma_y;
    assign fma_z         = r_fma_z;
    assign fma_roundmode = r_fma_ctrl[5:4];
    assign fma_mul       = r_fma_ctrl[3];
    assign fma_add       = r_fma_ctrl[2];
    assign fma_negp      = r_fma_ctrl[1];
    assign fma_negz      = r_fma_ctrl[0];
    assign rsp_result    = r_rsp_result;
    assign rsp_flags     = r_rsp_flags;
    assign sticky_flags0 = r_sticky0;
    assign sticky_flags1 = r_sticky1;
    assign op_count0     = r_op_count0;
    assign op_count1     = r_op_count1;

endmodule

// File: tb/tb_fma16_arb.sv
// Bench for fma16_arb: a stub stands in for fma16, a scoreboard queue holds expected responses.
module tb_fma16_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, flag_clr;
    logic [15:0] req_x0, req_y0, req_z0, req_x1, req_y1, req_z1;
    logic [5:0]  req_ctrl0, req_ctrl1;
    logic [15:0] rsp_result, fma_x, fma_y, fma_z, fma_result, op_count0, op_count1;
    logic [3:0]  rsp_flags, fma_flags, sticky_flags0, sticky_flags1;
    logic [1:0]  fma_roundmode;
    logic        fma_mul, fma_add, fma_negp, fma_negz;

    typedef struct packed {
        logic        c;
        logic [15:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fma16_arb dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x0(req_x0), .req_y0(req_y0), .req_z0(req_z0), .req_ctrl0(req_ctrl0),
        .req_x1(req_x1), .req_y1(req_y1), .req_z1(req_z1), .req_ctrl1(req_ctrl1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z), .fma_roundmode(fma_roundmode),
        .fma_mul(fma_mul), .fma_add(fma_add), .fma_negp(fma_negp), .fma_negz(fma_negz),
        .fma_result(fma_result), .fma_flags(fma_flags),
        .flag_clr(flag_clr),
        .sticky_flags0(sticky_flags0), .sticky_flags1(sticky_flags1),
        .op_count0(op_count0), .op_count1(op_count1)
    );

    task automatic set_ops(input int c, input logic [15:0] x, y, z, input logic [5:0] ctrl);
        if (c == 0) begin req_x0 = x; req_y0 = y; req_z0 = z; req_ctrl0 = ctrl; end
        else        begin req_x1 = x; req_y1 = y; req_z1 = z; req_ctrl1 = ctrl; end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input int c, input logic [15:0] x, y, z, input logic [5:0] ctrl,
                        input logic [15:0] res, input logic [3:0] flg);
        int k = 0;
        set_ops(c, x, y, z, ctrl);
        req_valid[c] = 1'b1;
        #1;
        while (!req_ready[c] && k < 20) begin @(negedge clk); #1; k++; end
        n_tests++;
        if (!req_ready[c]) begin
            n_fail++;
            $display("FAIL accept_c%0d: req_ready=%b, required grant within 20 cycles", c, req_ready);
            req_valid[c] = 1'b0;
        end else begin
            fma_result = res;
            fma_flags  = flg;
            sb.push_back('{c: c[0], res: res, flg: flg});
            $display("[TB] accept client %0d x=%h y=%h z=%h ctrl=%b", c, x, y, z, ctrl);
            @(negedge clk);
            req_valid[c] = 1'b0;
        end
    endtask

    // Waits for client c's response, checks it against the scoreboard, then handshakes.
    task automatic recv(input int c, input int delay, input logic clr);
        int   k = 0;
        exp_t e;
        while (!rsp_valid[c] && k < 20) begin @(negedge clk); k++; end
        n_tests++;
        if (!rsp_valid[c] || sb.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_timeout_c%0d: rsp_valid=%b queued=%0d, required response", c, rsp_valid, sb.size());
            return;
        end
        e = sb.pop_front();
        n_tests++;
        if (rsp_valid !== (2'b01 << e.c) || rsp_result !== e.res || rsp_flags !== e.flg) begin
            n_fail++;
            $display("FAIL rsp_c%0d: valid=%b result=%h flags=%b, required valid=%b result=%h flags=%b",
                     c, rsp_valid, rsp_result, rsp_flags, 2'b01 << e.c, e.res, e.flg);
        end
        $display("[TB] response client %0d result=%h flags=%b", c, rsp_result, rsp_flags);
        repeat (delay) @(negedge clk);
        rsp_ready[c] = 1'b1;
        flag_clr[c]  = clr;
        @(negedge clk);
        rsp_ready = 2'b00;
        flag_clr  = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_req_ready: got %b, required 00", req_ready);
        end
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if (rsp_valid !== 2'b00 || rsp_result !== 16'h0 || rsp_flags !== 4'h0 || fma_x !== 16'h0
            || fma_mul !== 1'b0 || sticky_flags0 !== 4'h0 || sticky_flags1 !== 4'h0
            || op_count0 !== 16'h0 || op_count1 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: rsp_valid=%b result=%h flags=%b fma_x=%h cnt0=%h cnt1=%h, required all zero",
                     rsp_valid, rsp_result, rsp_flags, fma_x, op_count0, op_count1);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_single();
        send(0, 16'h3C00, 16'h4000, 16'h3C00, 6'b001100, 16'h4200, 4'h0);
        n_tests++;
        if (rsp_valid !== 2'b00 || fma_x !== 16'h3C00 || fma_y !== 16'h4000 || fma_z !== 16'h3C00
            || {fma_roundmode, fma_mul, fma_add, fma_negp, fma_negz} !== 6'b001100) begin
            n_fail++;
            $display("FAIL single_issue: rsp_valid=%b fma=%h/%h/%h, required 00 and 3c00/4000/3c00", rsp_valid, fma_x, fma_y, fma_z);
        end
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 2'b01) begin
            n_fail++; $display("FAIL single_latency: rsp_valid=%b, required 01", rsp_valid);
        end
        recv(0, 0, 1'b0);
        n_tests++;
        if (op_count0 !== 16'd1) begin
            n_fail++; $display("FAIL single_count: op_count0=%h, required 0001", op_count0);
        end
    endtask

    task automatic test_contention();
        int   order [3] = '{0, 1, 0};
        int   c, k;
        exp_t e;
        do_reset();
        set_ops(0, 16'h1111, 16'h2222, 16'h3333, 6'b001000);
        set_ops(1, 16'h4444, 16'h5555, 16'h6666, 6'b000100);
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            c = order[i];
            k = 0;
            #1;
            while (req_ready === 2'b00 && k < 20) begin @(negedge clk); #1; k++; end
            n_tests++;
            if (req_ready !== (2'b01 << c)) begin
                n_fail++; $display("FAIL contention_grant%0d: req_ready=%b, required %b", i, req_ready, 2'b01 << c);
            end
            fma_result = 16'h1000 + 16'(i);
            fma_flags  = 4'(i + 1);
            sb.push_back('{c: c[0], res: 16'h1000 + 16'(i), flg: 4'(i + 1)});
            $display("[TB] contention grant %0d to client %0d", i, c);
            @(negedge clk);
            if (i == 2 || c == 1) req_valid[c] = 1'b0;
            k = 0;
            while (rsp_valid === 2'b00 && k < 20) begin @(negedge clk); k++; end
            e = sb.pop_front();
            n_tests++;
            if (rsp_valid !== (2'b01 << e.c) || rsp_result !== e.res || rsp_flags !== e.flg) begin
                n_fail++;
                $display("FAIL contention_rsp%0d: valid=%b result=%h flags=%b, required valid=%b result=%h flags=%b",
                         i, rsp_valid, rsp_result, rsp_flags, 2'b01 << e.c, e.res, e.flg);
            end
            rsp_ready[c] = 1'b1;
            @(negedge clk);
            rsp_ready = 2'b00;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_back_to_back_backpressure();
        exp_t e;
        int   k = 0;
        send(0, 16'h0101, 16'h0202, 16'h0303, 6'b011100, 16'hABCD, 4'b0001);
        while (!rsp_valid[0] && k < 20) begin @(negedge clk); k++; end
        fma_result = 16'h0000;
        fma_flags  = 4'h0;
        set_ops(1, 16'h7777, 16'h7777, 16'h7777, 6'b001100);
        req_valid[1] = 1'b1;
        rsp_ready[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (rsp_valid !== 2'b01 || rsp_result !== 16'hABCD || rsp_flags !== 4'b0001 || req_ready !== 2'b00) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d: valid=%b result=%h flags=%b req_ready=%b, required 01/abcd/0001/00",
                         i, rsp_valid, rsp_result, rsp_flags, req_ready);
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        n_tests++;
        if (rsp_result !== e.res || rsp_flags !== e.flg) begin
            n_fail++; $display("FAIL backpressure_rsp: result=%h flags=%b, required %h %b", rsp_result, rsp_flags, e.res, e.flg);
        end
        $display("[TB] backpressure response released");
        req_valid[1] = 1'b0;
        rsp_ready    = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        n_tests++;
        if (op_count0 !== 16'd3 || op_count1 !== 16'd1 || rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL backpressure_count: cnt0=%h cnt1=%h valid=%b, required 0003 0001 00", op_count0, op_count1, rsp_valid);
        end
    endtask

    task automatic test_sticky();
        do_reset();
        send(1, 16'h1, 16'h2, 16'h3, 6'b001100, 16'h0AAA, 4'b0100);
        recv(1, 1, 1'b0);
        send(1, 16'h4, 16'h5, 16'h6, 6'b001110, 16'h0BBB, 4'b0001);
        recv(1, 0, 1'b0);
        n_tests++;
        if (sticky_flags1 !== 4'b0101 || sticky_flags0 !== 4'b0000) begin
            n_fail++; $display("FAIL sticky_accum: sticky1=%b sticky0=%b, required 0101 0000", sticky_flags1, sticky_flags0);
        end
        send(1, 16'h7, 16'h8, 16'h9, 6'b101100, 16'h0CCC, 4'b1000);
        recv(1, 0, 1'b1);
        n_tests++;
        if (sticky_flags1 !== 4'b1000 || op_count1 !== 16'd3) begin
            n_fail++; $display("FAIL sticky_clr_hs: sticky1=%b cnt1=%h, required 1000 0003", sticky_flags1, op_count1);
        end
        flag_clr = 2'b10;
        @(negedge clk);
        flag_clr = 2'b00;
        n_tests++;
        if (sticky_flags1 !== 4'b0000) begin
            n_fail++; $display("FAIL sticky_clr: sticky1=%b, required 0000", sticky_flags1);
        end
    endtask

    task automatic test_reset_resp();
        int k = 0;
        send(0, 16'h1, 16'h1, 16'h1, 6'b001100, 16'h1234, 4'b0010);
        recv(0, 0, 1'b0);
        send(0, 16'h2, 16'h2, 16'h2, 6'b001100, 16'h5678, 4'b0001);
        while (!rsp_valid[0] && k < 20) begin @(negedge clk); k++; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        n_tests++;
        if (rsp_valid !== 2'b00 || op_count0 !== 16'h0 || sticky_flags0 !== 4'h0 || op_count1 !== 16'h0 || fma_x !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_resp: valid=%b cnt0=%h sticky0=%b cnt1=%h fma_x=%h, required all zero",
                     rsp_valid, op_count0, sticky_flags0, op_count1, fma_x);
        end
        req_valid = 2'b11;
        #1;
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL reset_resp_prio: req_ready=%b, required 01", req_ready);
        end
        req_valid = 2'b00;
        $display("[TB] reset during response checked");
        @(negedge clk);
    endtask

    task automatic test_wrap();
        force dut.r_op_count0 = 16'hFFFE;
        @(negedge clk);
        release dut.r_op_count0;
        send(0, 16'h3C00, 16'h3C00, 16'h0000, 6'b001000, 16'h3C00, 4'h0);
        recv(0, 0, 1'b0);
        n_tests++;
        if (op_count0 !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_ffff: op_count0=%h, required ffff", op_count0);
        end
        send(0, 16'h3C00, 16'h3C00, 16'h0000, 6'b001000, 16'h3C00, 4'h0);
        recv(0, 0, 1'b0);
        n_tests++;
        if (op_count0 !== 16'h0000 || op_count1 !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_zero: op_count0=%h op_count1=%h, required 0000 0000", op_count0, op_count1);
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b00;
        rsp_ready  = 2'b00;
        flag_clr   = 2'b00;
        fma_result = 16'h0000;
        fma_flags  = 4'h0;
        set_ops(0, 16'h0, 16'h0, 16'h0, 6'h0);
        set_ops(1, 16'h0, 16'h0, 16'h0, 6'h0);
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_back_to_back_backpressure();
        test_sticky();
        test_reset_resp();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
